// File: rtl/sar_logic_par.sv
// Parametrised SAR controller for the split-capacitor fine DAC. It runs an N-bit binary search
// with a bottom-plate drain phase, a minimum sample time, pending/continuous start and overrun flagging.
module sar_logic_param #(
    parameter int unsigned N_BITS        = 8,
    parameter int unsigned DRAIN_CYCLES  = 2,
    parameter int unsigned SAMPLE_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnvst,
    input  logic                  cont,
    input  logic                  ovr_clr,
    input  logic                  cmp_out,
    output logic [N_BITS-1:0]     sar,
    output logic [N_BITS-1:0]     dout,
    output logic                  eoc,
    output logic                  busy,
    output logic                  ovr,
    output logic                  cmp_clk,
    output logic                  s_clk,
    output logic [2*N_BITS-1:0]   fine_btm,
    output logic                  fine_switch_drain,
    output logic                  s_clk_not,
    output logic [2*N_BITS-1:0]   fine_btm_not,
    output logic                  fine_switch_drain_not
);

    localparam int unsigned B_W  = $clog2(N_BITS);
    localparam int unsigned FB_W = 2 * N_BITS;
    localparam int unsigned FI_W = $clog2(FB_W);
    localparam int unsigned DR_W = 4;
    localparam int unsigned SC_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        COMPRST = 2'd2,
        DECIDE  = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [B_W-1:0]    b, b_d, b_m1;
    logic [DR_W-1:0]   drain, drain_d;
    logic [SC_W-1:0]   samp_cnt, samp_cnt_d;
    logic              pending, pending_d;
    logic [N_BITS-1:0] sar_d, dout_d;
    logic [FB_W-1:0]   fine_btm_d;
    logic              eoc_d, cmp_clk_d, fsd_d, ovr_d;

    assign busy                  = (state != IDLE);
    assign s_clk                 = rst | (state == IDLE);
    assign s_clk_not             = ~s_clk;
    assign fine_btm_not          = ~fine_btm;
    assign fine_switch_drain_not = ~fine_switch_drain;
    assign b_m1                  = b - B_W'(1);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            sar               <= '0;
            b                 <= '0;
            drain             <= '0;
            samp_cnt          <= SC_W'(SAMPLE_CYCLES);
            pending           <= 1'b0;
            dout              <= '0;
            eoc               <= 1'b0;
            cmp_clk           <= 1'b0;
            fine_btm          <= '0;
            fine_switch_drain <= 1'b0;
            ovr               <= 1'b0;
        end else begin
            state             <= state_d;
            sar               <= sar_d;
            b                 <= b_d;
            drain             <= drain_d;
            samp_cnt          <= samp_cnt_d;
            pending           <= pending_d;
            dout              <= dout_d;
            eoc               <= eoc_d;
            cmp_clk           <= cmp_clk_d;
            fine_btm          <= fine_btm_d;
            fine_switch_drain <= fsd_d;
            ovr               <= ovr_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        sar_d      = sar;
        b_d        = b;
        drain_d    = drain;
        samp_cnt_d = samp_cnt;
        pending_d  = pending;
        dout_d     = dout;
        eoc_d      = 1'b0;
        cmp_clk_d  = 1'b0;
        fine_btm_d = fine_btm;
        fsd_d      = fine_switch_drain;
        ovr_d      = ovr;

        // Set has priority over clear
        if (ovr_clr)
            ovr_d = 1'b0;
        if (cnvst && busy)
            ovr_d = 1'b1;

        case (state)
            IDLE: begin
                sar_d      = {1'b1, {(N_BITS-1){1'b0}}};
                b_d        = B_W'(N_BITS - 1);
                drain_d    = DR_W'(DRAIN_CYCLES);
                fine_btm_d = '0;
                fsd_d      = 1'b0;
                if (samp_cnt != '0) begin
                    samp_cnt_d = samp_cnt - SC_W'(1);
                    if (cnvst)
                        pending_d = 1'b1;
                end else if (cnvst || pending || cont) begin
                    state_d   = DRAIN;
                    pending_d = 1'b0;
                end
            end
            DRAIN: begin
                fsd_d = (drain >= DR_W'(2));
                if (drain != '0) begin
                    drain_d = drain - DR_W'(1);
                end else begin
                    state_d    = COMPRST;
                    fine_btm_d = {{N_BITS{1'b1}}, {N_BITS{1'b0}}};
                end
            end
            COMPRST: begin
                state_d   = DECIDE;
                cmp_clk_d = 1'b1;
            end
            DECIDE: begin
                if (!cmp_out) begin
                    sar_d[b]                             = 1'b0;
                    fine_btm_d[FI_W'(b) + FI_W'(N_BITS)] = 1'b0;
                end else begin
                    fine_btm_d[b] = 1'b1;
                end
                if (b != '0) begin
                    sar_d[b_m1] = 1'b1;
                    b_d         = b_m1;
                    state_d     = COMPRST;
                end else begin
                    state_d    = IDLE;
                    eoc_d      = 1'b1;
                    dout_d     = {sar[N_BITS-1:1], cmp_out};
                    samp_cnt_d = SC_W'(SAMPLE_CYCLES);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_logic_param.sv
// Bench for sar_logic_param: two instances (8b/D2/S0 and 12b/D3/S3) driven by an ideal comparator
// against a random analog code; expected codes, latencies and pulse positions come from a timing model.
module tb_sar_logic_param;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=8, D=2, S=0
    logic        rst_a, cnvst_a, cont_a, ovr_clr_a, cmp_a;
    logic [7:0]  sar_a, dout_a, vin_a;
    logic        eoc_a, busy_a, ovr_a, cmp_clk_a, s_clk_a, fsd_a, s_clk_n_a, fsd_n_a;
    logic [15:0] fine_a, fine_n_a;

    // Instance B: N=12, D=3, S=3
    logic        rst_b, cnvst_b, cont_b, ovr_clr_b, cmp_b;
    logic [11:0] sar_b, dout_b, vin_b;
    logic        eoc_b, busy_b, ovr_b, cmp_clk_b, s_clk_b, fsd_b, s_clk_n_b, fsd_n_b;
    logic [23:0] fine_b, fine_n_b;

    assign cmp_a = (vin_a >= sar_a);
    assign cmp_b = (vin_b >= sar_b);

    sar_logic_param #(.N_BITS(8), .DRAIN_CYCLES(2), .SAMPLE_CYCLES(0)) u_a (
        .clk(clk), .rst(rst_a), .cnvst(cnvst_a), .cont(cont_a), .ovr_clr(ovr_clr_a),
        .cmp_out(cmp_a), .sar(sar_a), .dout(dout_a), .eoc(eoc_a), .busy(busy_a), .ovr(ovr_a),
        .cmp_clk(cmp_clk_a), .s_clk(s_clk_a), .fine_btm(fine_a), .fine_switch_drain(fsd_a),
        .s_clk_not(s_clk_n_a), .fine_btm_not(fine_n_a), .fine_switch_drain_not(fsd_n_a)
    );

    sar_logic_param #(.N_BITS(12), .DRAIN_CYCLES(3), .SAMPLE_CYCLES(3)) u_b (
        .clk(clk), .rst(rst_b), .cnvst(cnvst_b), .cont(cont_b), .ovr_clr(ovr_clr_b),
        .cmp_out(cmp_b), .sar(sar_b), .dout(dout_b), .eoc(eoc_b), .busy(busy_b), .ovr(ovr_b),
        .cmp_clk(cmp_clk_b), .s_clk(s_clk_b), .fine_btm(fine_b), .fine_switch_drain(fsd_b),
        .s_clk_not(s_clk_n_b), .fine_btm_not(fine_n_b), .fine_switch_drain_not(fsd_n_b)
    );

    // Observation mux so one set of tasks serves both instances
    logic        sel;
    logic        m_eoc, m_busy, m_ovr, m_cmp_clk, m_s_clk, m_fsd, m_not_ok;
    logic [15:0] m_dout, m_sar;
    logic [31:0] m_fine;

    always_comb begin
        m_eoc     = sel ? eoc_b     : eoc_a;
        m_busy    = sel ? busy_b    : busy_a;
        m_ovr     = sel ? ovr_b     : ovr_a;
        m_cmp_clk = sel ? cmp_clk_b : cmp_clk_a;
        m_s_clk   = sel ? s_clk_b   : s_clk_a;
        m_fsd     = sel ? fsd_b     : fsd_a;
        m_dout    = sel ? 16'(dout_b) : 16'(dout_a);
        m_sar     = sel ? 16'(sar_b)  : 16'(sar_a);
        m_fine    = sel ? 32'(fine_b) : 32'(fine_a);
        m_not_ok  = sel ? ((s_clk_n_b === ~s_clk_b) && (fine_n_b === ~fine_b) && (fsd_n_b === ~fsd_b))
                        : ((s_clk_n_a === ~s_clk_a) && (fine_n_a === ~fine_a) && (fsd_n_a === ~fsd_a));
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input logic v);
        sel = v;
        #1;
    endtask

    task automatic set_in(input logic cv, input logic clr);
        if (sel) begin
            cnvst_b   = cv;
            ovr_clr_b = clr;
        end else begin
            cnvst_a   = cv;
            ovr_clr_a = clr;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One conversion started by a cnvst pulse; optional cnvst injection at cycle inj_at after the
    // start edge, and an optional cnvst pulse right after eoc to exercise the pending request.
    task automatic run_conv(input int nb, input int d, input int s, input logic [15:0] vin,
                            input int inj_at, input logic inj_clr, input logic post_pend,
                            input string tag);
        int          n;
        int          fsd_bad, cclk_bad, sclk_bad;
        logic        done;
        logic        exp_fsd, exp_cc;
        logic [31:0] exp_fine;
        if (sel) vin_b = vin[11:0]; else vin_a = vin[7:0];
        exp_fine = (32'(vin) << nb) | 32'(vin);
        set_in(1'b1, 1'b0);
        @(negedge clk);
        check({tag, "_busy"}, 32'(m_busy), 32'd1);
        fsd_bad = 0; cclk_bad = 0; sclk_bad = 0; done = 1'b0;
        for (n = 1; n <= d + 1 + 2 * nb + 4; n++) begin
            if (n - 1 == inj_at) set_in(1'b1, inj_clr); else set_in(1'b0, 1'b0);
            @(negedge clk);
            if (m_eoc) begin
                done = 1'b1;
                break;
            end
            exp_fsd = (n <= d - 1);
            exp_cc  = (n >= d + 2) && (((n - d - 2) % 2) == 0);
            if (m_fsd !== exp_fsd) fsd_bad++;
            if (m_cmp_clk !== exp_cc) cclk_bad++;
            if (m_s_clk !== 1'b0) sclk_bad++;
        end
        set_in(1'b0, 1'b0);
        check({tag, "_eoc_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(d + 1 + 2 * nb));
        check({tag, "_drain_pulse"}, 32'(fsd_bad), 32'd0);
        check({tag, "_cmp_clk_pos"}, 32'(cclk_bad), 32'd0);
        check({tag, "_s_clk_low"}, 32'(sclk_bad), 32'd0);
        check({tag, "_dout"}, 32'(m_dout), 32'(vin));
        check({tag, "_sar"}, 32'(m_sar), 32'(vin));
        check({tag, "_fine_btm"}, m_fine, exp_fine);
        check({tag, "_idle_at_eoc"}, {30'd0, m_busy, m_s_clk}, 32'd1);
        check({tag, "_inverses"}, 32'(m_not_ok), 32'd1);
        if (post_pend) begin
            set_in(1'b1, 1'b0);
            @(negedge clk);
            set_in(1'b0, 1'b0);
            check({tag, "_eoc_width"}, 32'(m_eoc), 32'd0);
            for (int j = 2; j <= s; j++) begin
                @(negedge clk);
                check({tag, "_pend_wait"}, 32'(m_busy), 32'd0);
            end
            @(negedge clk);
            check({tag, "_pend_start"}, 32'(m_busy), 32'd1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!m_eoc && n < 200);
            check({tag, "_pend_latency"}, 32'(n), 32'(d + 1 + 2 * nb));
            check({tag, "_pend_dout"}, 32'(m_dout), 32'(vin));
            check({tag, "_pend_ovr"}, 32'(m_ovr), 32'd0);
        end
        @(negedge clk);
        check({tag, "_eoc_end"}, 32'(m_eoc), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          n, sh;
        logic [15:0] v;
        rst_a = 1'b1; cnvst_a = 1'b0; cont_a = 1'b0; ovr_clr_a = 1'b0; vin_a = '0;
        rst_b = 1'b1; cnvst_b = 1'b0; cont_b = 1'b0; ovr_clr_b = 1'b0; vin_b = '0;
        sel = 1'b0;
        idle(2);

        // Reset values on both instances
        for (int k = 0; k < 2; k++) begin
            set_sel(k[0]);
            check("rst_busy", 32'(m_busy), 32'd0);
            check("rst_sar", 32'(m_sar), 32'd0);
            check("rst_dout", 32'(m_dout), 32'd0);
            check("rst_outs", {27'd0, m_eoc, m_cmp_clk, m_fsd, m_ovr, m_s_clk}, 32'd1);
            check("rst_fine", m_fine, 32'd0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // A: alternating decisions, then random codes
        set_sel(1'b0);
        run_conv(8, 2, 0, 16'h00AA, -1, 1'b0, 1'b0, "a_aa");
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom_range(0, 255));
            run_conv(8, 2, 0, v, -1, 1'b0, 1'b0, "a_rand");
        end
        run_conv(8, 2, 0, 16'h00FF, -1, 1'b0, 1'b0, "a_ff");
        run_conv(8, 2, 0, 16'h0000, -1, 1'b0, 1'b0, "a_00");

        // A: overrun during DECIDE, clear, then set-wins-over-clear
        run_conv(8, 2, 0, 16'h005C, 4, 1'b0, 1'b0, "a_ovr");
        check("ovr_set", 32'(m_ovr), 32'd1);
        idle(4);
        check("ovr_no_extra_conv", 32'(m_busy), 32'd0);
        set_in(1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0);
        check("ovr_cleared", 32'(m_ovr), 32'd0);
        run_conv(8, 2, 0, 16'h0033, 6, 1'b1, 1'b0, "a_ovr_clr");
        check("ovr_set_wins", 32'(m_ovr), 32'd1);
        set_in(1'b0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0);
        check("ovr_cleared2", 32'(m_ovr), 32'd0);

        // A: reset during the third DECIDE aborts the conversion
        vin_a = 8'($urandom);
        set_in(1'b1, 1'b0);
        @(negedge clk);
        set_in(1'b0, 1'b0);
        idle(8);
        check("rst_in_decide", 32'(m_cmp_clk), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_sar", 32'(m_sar), 32'd0);
        check("abort_fine", m_fine, 32'd0);
        check("abort_dout", 32'(m_dout), 32'd0);
        check("abort_outs", {29'd0, m_eoc, m_cmp_clk, m_s_clk}, 32'd1);
        rst_a = 1'b0;
        @(negedge clk);
        run_conv(8, 2, 0, 16'h0091, -1, 1'b0, 1'b0, "a_post_rst");

        // B: extremes, random codes, pending request
        set_sel(1'b1);
        idle(5);
        run_conv(12, 3, 3, 16'h0FFF, -1, 1'b0, 1'b0, "b_fff");
        idle(5);
        run_conv(12, 3, 3, 16'h0000, -1, 1'b0, 1'b0, "b_000");
        for (int i = 0; i < 3; i++) begin
            idle(5);
            v = 16'($urandom_range(0, 4095));
            run_conv(12, 3, 3, v, -1, 1'b0, 1'b0, "b_rand");
        end
        idle(5);
        v = 16'($urandom_range(0, 4095));
        run_conv(12, 3, 3, v, -1, 1'b0, 1'b1, "b_pend");

        // B: continuous mode, eoc period and sample window
        idle(5);
        cont_b = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eoc_b && n < 100);
        check("cont_first_eoc", 32'(eoc_b), 32'd1);
        for (int c = 0; c < 3; c++) begin
            vin_b = 12'($urandom);
            n = 0; sh = 0;
            do begin
                @(negedge clk);
                n++;
                if (s_clk_b) sh++;
            end while (!eoc_b && n < 100);
            check("cont_period", 32'(n), 32'd32);
            check("cont_s_clk_high", 32'(sh), 32'd4);
            check("cont_dout", 32'(dout_b), 32'(vin_b));
        end
        cont_b = 1'b0;
        idle(8);
        check("cont_stop", 32'(busy_b), 32'd0);
        check("cont_no_ovr", 32'(ovr_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
